echo_seq_gen: RTL and testbench
===============================

Name: echo_seq_gen

Overview:
- Trigger-started RF gate sequencer for spin-echo / CPMG pulse trains.
- Drives the RF switch controller with the following sequence, where N = n_pi and every gap is rf low:
  - π/2 pulse, then τ gap.
  - N π pulses, separated by 2τ gaps.
  - τ gap, then final π/2 pulse.
- Runtime-programmable pulse length, free-evolution time and π-pulse count.
- Successor to the fixed single-sequence controller. Sits between the host register block and the rf output pin.

Parameters:
- CNT_W, 16, width of length inputs and internal cycle counters.
- NPI_W, 8, width of the n_pi count input.

Ports:
- clk  in  1  FPGA system clock.
- rst  in  1  synchronous active-high reset.
- trig  in  1  sequence start request; rising edge sampled on clk.
- abort  in  1  synchronous abort, level-sensitive.
- half_pi_len  in  CNT_W  π/2 pulse length in clk cycles.
- tau_len  in  CNT_W  free-evolution time τ in clk cycles.
- n_pi  in  NPI_W  number of π pulses; 0 gives a Ramsey sequence.
- rf  out  1  RF gate; 1 = RF on.
- busy  out  1  high while a sequence is running.
- done  out  1  one-cycle pulse when a sequence completes normally.
- trig_missed  out  1  sticky flag: a trigger edge arrived while busy.

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high; one rst cycle is sufficient.
- Reset values: rf=0, busy=0, done=0, trig_missed=0, FSM=IDLE, all counters 0, trig edge-detect history=0.
- Registered outputs: all outputs are registered; none are combinational from inputs.
- Trigger edge: trig_edge = trig & ~trig_d, where trig_d is trig delayed by one cycle.
- Start:
  - A trig_edge seen in IDLE at cycle k latches half_pi_len, tau_len and n_pi into shadow registers.
  - Input changes after cycle k do not affect the running sequence.
  - rf=1 and busy=1 from cycle k+1.
- Zero lengths: any latched length of 0 is treated as 1.
- π length: exactly 2 × half_pi_len, computed at CNT_W+1 bits with no overflow.
- 2τ gap: 2 × tau_len, computed at CNT_W+1 bits.
- FSM states: IDLE, P90A, GAP_T, PI, GAP_2T, GAP_TL, P90B, DONE.
  - IDLE → P90A on trig_edge.
  - P90A (rf=1, half_pi_len cycles) → GAP_T.
  - GAP_T (rf=0, τ cycles) → PI if n_pi>0, else P90B.
  - PI (rf=1, π cycles): decrement the remaining-π counter, then go to GAP_2T if remaining > 0, else GAP_TL.
  - GAP_2T (rf=0, 2τ cycles) → PI.
  - GAP_TL (rf=0, τ cycles) → P90B.
  - P90B (rf=1, half_pi_len cycles) → DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then → IDLE.
- Gaps: no idle cycles are inserted between states. Each state occupies exactly its length in cycles.
- Total length: busy is high for 2h + N·2h + 2τ + max(N−1,0)·2τ cycles, where h = half_pi_len. For n_pi=0 it is 2h+τ.
- Trigger during a sequence: a trig_edge while busy=1 or in DONE is ignored and sets trig_missed=1.
- trig_missed clearing: cleared on the cycle a new sequence starts. If the clearing start and a new miss coincide, the miss wins.
- Abort:
  - abort=1 in any non-IDLE state: the next cycle has rf=0, busy=0, FSM=IDLE and done=0.
  - abort in IDLE has no effect.
  - If abort and trig_edge occur in the same IDLE cycle, abort wins and the sequence does not start.
- Back-to-back: a trig_edge on the DONE cycle is a miss. The earliest accepted re-trigger is the first IDLE cycle.
- Reset mid-sequence: rf drops on the cycle after rst is sampled, and all state returns to reset values.

Optional Feature:
- Macro: ECHO_SEQ_TRIG_SYNC_EN.
- Defined:
  - trig passes through a 2-flop synchronizer (reset to 0) before edge detection.
  - Start latency grows by 2 cycles: rf rises at k+3, where k is the first cycle trig=1 is sampled.
- Undefined: no synchronizer; trig must already be synchronous to clk, and rf rises at k+1.

Test Plan:
- Ramsey: h=3, τ=5, n_pi=0, trig edge at cycle 0 → rf=1 cycles 1–3, 0 cycles 4–8, 1 cycles 9–11; done=1 at cycle 12 only; busy=1 cycles 1–11.
- Hahn echo: h=3, τ=5, n_pi=1, edge at cycle 0 → rf=1 at 1–3, 9–14, 20–22; done at cycle 23.
- CPMG: h=3, τ=5, n_pi=2, edge at cycle 0 → rf=1 at 1–3, 9–14, 25–30, 36–38; done at cycle 39. Changing inputs at cycle 5 does not alter this timing.
- Re-trigger while busy: second edge at cycle 6 of the Ramsey case → timing unchanged; trig_missed=1 from cycle 7; next accepted start clears it.
- Abort: abort=1 at cycle 10 of the Hahn case → rf=0 and busy=0 from cycle 11; done never pulses.
- Zero lengths and reset: h=0, τ=0, n_pi=0 → rf=1 at cycle 1, 0 at cycle 2, 1 at cycle 3, done at cycle 4. rst asserted during a P90A cycle → all outputs 0 the following cycle.

Source files
------------

// File: rtl/echo_seq_gen.sv
// Trigger-started RF gate sequencer for spin-echo / CPMG trains: pi/2 - tau - N x (pi - 2tau) - tau - pi/2.
// Optional 2-flop trigger synchronizer enabled by defining ECHO_SEQ_TRIG_SYNC_EN.
module echo_seq_gen #(
    parameter int CNT_W = 16,
    parameter int NPI_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] half_pi_len,
    input  logic [CNT_W-1:0] tau_len,
    input  logic [NPI_W-1:0] n_pi,
    output logic             rf,
    output logic             busy,
    output logic             done,
    output logic             trig_missed
);

    typedef enum logic [2:0] {
        IDLE,
        P90A,
        GAP_T,
        PI,
        GAP_2T,
        GAP_TL,
        P90B,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   ONE_X = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [NPI_W-1:0] ONE_N = {{(NPI_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [CNT_W:0]   cnt_reg, cnt_next;
    logic [NPI_W-1:0] pi_rem_reg, pi_rem_next;
    logic [CNT_W-1:0] h_reg, tau_reg;
    logic             trig_d_reg;
    logic             rf_reg, busy_reg, done_reg, trig_missed_reg;
    logic             rf_next, busy_next, done_next, trig_missed_next;
    logic             load_shadow;
    logic             trig_in;
    logic             trig_edge;
    logic             last;
    logic [CNT_W-1:0] h_start;
    logic [CNT_W:0]   h_len, pi_len, tau_x, tau2_len;

`ifdef ECHO_SEQ_TRIG_SYNC_EN
    logic trig_meta_reg, trig_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_meta_reg <= 1'b0;
            trig_sync_reg <= 1'b0;
        end else begin
            trig_meta_reg <= trig;
            trig_sync_reg <= trig_meta_reg;
        end
    end

    assign trig_in = trig_sync_reg;
`else
    assign trig_in = trig;
`endif

    assign trig_edge = trig_in & ~trig_d_reg;
    assign last      = (cnt_reg == '0);

    // Shadow lengths are stored already clamped to >= 1; doubled forms need the extra bit.
    assign h_start  = (half_pi_len == '0) ? ONE_C : half_pi_len;
    assign h_len    = {1'b0, h_reg};
    assign pi_len   = {h_reg, 1'b0};
    assign tau_x    = {1'b0, tau_reg};
    assign tau2_len = {tau_reg, 1'b0};

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pi_rem_next = pi_rem_reg;
        load_shadow = 1'b0;

        case (state_reg)
            IDLE: begin
                if (trig_edge && !abort) begin
                    state_next  = P90A;
                    cnt_next    = {1'b0, h_start} - ONE_X;
                    pi_rem_next = n_pi;
                    load_shadow = 1'b1;
                end
            end
            P90A: begin
                if (last) begin
                    state_next = GAP_T;
                    cnt_next   = tau_x - ONE_X;
                end else begin
                    cnt_next = cnt_reg - ONE_X;
                end
            end
            GAP_T: begin
                if (last) begin
                    if (pi_rem_reg != '0) begin
                        state_next = PI;
                        cnt_next   = pi_len - ONE_X;
                    end else begin
                        state_next = P90B;
                        cnt_next   = h_len - ONE_X;
                    end
                end else begin
                    cnt_next = cnt_reg - ONE_X;
                end
            end
            PI: begin
                if (last) begin
                    pi_rem_next = pi_rem_reg - ONE_N;
                    if (pi_rem_reg > ONE_N) begin
                        state_next = GAP_2T;
                        cnt_next   = tau2_len - ONE_X;
                    end else begin
                        state_next = GAP_TL;
                        cnt_next   = tau_x - ONE_X;
                    end
                end else begin
                    cnt_next = cnt_reg - ONE_X;
                end
            end
            GAP_2T: begin
                if (last) begin
                    state_next = PI;
                    cnt_next   = pi_len - ONE_X;
                end else begin
                    cnt_next = cnt_reg - ONE_X;
                end
            end
            GAP_TL: begin
                if (last) begin
                    state_next = P90B;
                    cnt_next   = h_len - ONE_X;
                end else begin
                    cnt_next = cnt_reg - ONE_X;
                end
            end
            P90B: begin
                if (last) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - ONE_X;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (abort && (state_reg != IDLE)) begin
            state_next  = IDLE;
            cnt_next    = '0;
            pi_rem_next = '0;
        end
    end

    // Outputs are decoded from the next state so they appear registered in the state's own cycle.
    always_comb begin
        rf_next   = (state_next == P90A) || (state_next == PI) || (state_next == P90B);
        busy_next = (state_next != IDLE) && (state_next != DONE);
        done_next = (state_next == DONE);

        trig_missed_next = trig_missed_reg;
        if (load_shadow) begin
            trig_missed_next = 1'b0;
        end
        if (trig_edge && (state_reg != IDLE)) begin
            trig_missed_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            pi_rem_reg      <= '0;
            h_reg           <= '0;
            tau_reg         <= '0;
            trig_d_reg      <= 1'b0;
            rf_reg          <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            trig_missed_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            pi_rem_reg      <= pi_rem_next;
            trig_d_reg      <= trig_in;
            rf_reg          <= rf_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            trig_missed_reg <= trig_missed_next;
            if (load_shadow) begin
                h_reg   <= h_start;
                tau_reg <= (tau_len == '0) ? ONE_C : tau_len;
            end
        end
    end

    assign rf          = rf_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign trig_missed = trig_missed_reg;

endmodule

// File: tb/tb_echo_seq_gen.sv
// Directed-vector bench for echo_seq_gen: Ramsey, Hahn, CPMG, re-trigger, abort, zero lengths, reset.
module tb_echo_seq_gen;

    localparam int CNT_W = 16;
    localparam int NPI_W = 8;
`ifdef ECHO_SEQ_TRIG_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             trig;
    logic             abort;
    logic [CNT_W-1:0] half_pi_len;
    logic [CNT_W-1:0] tau_len;
    logic [NPI_W-1:0] n_pi;
    logic             rf, busy, done, trig_missed;

    int vectors = 0;
    int miscompares = 0;

    echo_seq_gen #(.CNT_W(CNT_W), .NPI_W(NPI_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .abort       (abort),
        .half_pi_len (half_pi_len),
        .tau_len     (tau_len),
        .n_pi        (n_pi),
        .rf          (rf),
        .busy        (busy),
        .done        (done),
        .trig_missed (trig_missed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; trig = 1'b0; abort = 1'b0;
        half_pi_len = '0; tau_len = '0; n_pi = '0;
        repeat (3) step();
        vectors += 4;
        if (rf !== 1'b0)          begin miscompares++; $display("FAIL reset_rf got %b want 0", rf); end
        if (busy !== 1'b0)        begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)        begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        if (trig_missed !== 1'b0) begin miscompares++; $display("FAIL reset_trig_missed got %b want 0", trig_missed); end
        $display("reset: rf=%b busy=%b done=%b trig_missed=%b", rf, busy, done, trig_missed);
        rst = 1'b0;
        repeat (4) step();
    endtask

    // Ramsey h=3 tau=5 N=0 with a second edge at cycle 6 that must be flagged, not obeyed.
    task automatic test_ramsey_retrig();
        logic e_rf, e_busy, e_done, e_tm;
        half_pi_len = 16'd3; tau_len = 16'd5; n_pi = 8'd0;
        trig = 1'b1;
        for (int n = 1; n <= 14 + L; n++) begin
            int c;
            step();
            c = n - L;
            e_rf   = (c >= 1 && c <= 3) || (c >= 9 && c <= 11);
            e_busy = (c >= 1 && c <= 11);
            e_done = (c == 12);
            e_tm   = (c >= 7);
            vectors += 4;
            if (rf !== e_rf)          begin miscompares++; $display("FAIL ramsey_rf c=%0d got %b want %b", c, rf, e_rf); end
            if (busy !== e_busy)      begin miscompares++; $display("FAIL ramsey_busy c=%0d got %b want %b", c, busy, e_busy); end
            if (done !== e_done)      begin miscompares++; $display("FAIL ramsey_done c=%0d got %b want %b", c, done, e_done); end
            if (trig_missed !== e_tm) begin miscompares++; $display("FAIL ramsey_trig_missed c=%0d got %b want %b", c, trig_missed, e_tm); end
            $display("ramsey c=%0d rf=%b busy=%b done=%b tm=%b", c, rf, busy, done, trig_missed);
            if (n == 1) trig = 1'b0;
            if (n == 6) trig = 1'b1;
            if (n == 7) trig = 1'b0;
        end
        repeat (3) step();
    endtask

    task automatic test_hahn();
        logic e_rf, e_busy, e_done, e_tm;
        vectors++;
        if (trig_missed !== 1'b1) begin miscompares++; $display("FAIL hahn_pre_trig_missed got %b want 1", trig_missed); end
        half_pi_len = 16'd3; tau_len = 16'd5; n_pi = 8'd1;
        trig = 1'b1;
        for (int n = 1; n <= 25 + L; n++) begin
            int c;
            step();
            c = n - L;
            e_rf   = (c >= 1 && c <= 3) || (c >= 9 && c <= 14) || (c >= 20 && c <= 22);
            e_busy = (c >= 1 && c <= 22);
            e_done = (c == 23);
            e_tm   = (c < 1);
            vectors += 4;
            if (rf !== e_rf)          begin miscompares++; $display("FAIL hahn_rf c=%0d got %b want %b", c, rf, e_rf); end
            if (busy !== e_busy)      begin miscompares++; $display("FAIL hahn_busy c=%0d got %b want %b", c, busy, e_busy); end
            if (done !== e_done)      begin miscompares++; $display("FAIL hahn_done c=%0d got %b want %b", c, done, e_done); end
            if (trig_missed !== e_tm) begin miscompares++; $display("FAIL hahn_trig_missed c=%0d got %b want %b", c, trig_missed, e_tm); end
            $display("hahn c=%0d rf=%b busy=%b done=%b tm=%b", c, rf, busy, done, trig_missed);
            if (n == 1) trig = 1'b0;
        end
        repeat (3) step();
    endtask

    // CPMG N=2; inputs are scrambled mid-sequence and must not disturb the latched timing.
    task automatic test_cpmg();
        logic e_rf, e_busy, e_done;
        half_pi_len = 16'd3; tau_len = 16'd5; n_pi = 8'd2;
        trig = 1'b1;
        for (int n = 1; n <= 41 + L; n++) begin
            int c;
            step();
            c = n - L;
            e_rf   = (c >= 1 && c <= 3) || (c >= 9 && c <= 14) || (c >= 25 && c <= 30) || (c >= 36 && c <= 38);
            e_busy = (c >= 1 && c <= 38);
            e_done = (c == 39);
            vectors += 3;
            if (rf !== e_rf)     begin miscompares++; $display("FAIL cpmg_rf c=%0d got %b want %b", c, rf, e_rf); end
            if (busy !== e_busy) begin miscompares++; $display("FAIL cpmg_busy c=%0d got %b want %b", c, busy, e_busy); end
            if (done !== e_done) begin miscompares++; $display("FAIL cpmg_done c=%0d got %b want %b", c, done, e_done); end
            $display("cpmg c=%0d rf=%b busy=%b done=%b", c, rf, busy, done);
            if (n == 1) trig = 1'b0;
            if (n == 5 + L) begin half_pi_len = 16'd7; tau_len = 16'd2; n_pi = 8'd9; end
        end
        repeat (3) step();
    endtask

    task automatic test_abort();
        logic e_rf, e_busy;
        half_pi_len = 16'd3; tau_len = 16'd5; n_pi = 8'd1;
        trig = 1'b1;
        for (int n = 1; n <= 26 + L; n++) begin
            int c;
            step();
            c = n - L;
            e_rf   = (c >= 1 && c <= 3) || (c >= 9 && c <= 10);
            e_busy = (c >= 1 && c <= 10);
            vectors += 3;
            if (rf !== e_rf)     begin miscompares++; $display("FAIL abort_rf c=%0d got %b want %b", c, rf, e_rf); end
            if (busy !== e_busy) begin miscompares++; $display("FAIL abort_busy c=%0d got %b want %b", c, busy, e_busy); end
            if (done !== 1'b0)   begin miscompares++; $display("FAIL abort_done c=%0d got %b want 0", c, done); end
            $display("abort c=%0d rf=%b busy=%b done=%b", c, rf, busy, done);
            if (n == 1) trig = 1'b0;
            if (n == 10 + L) abort = 1'b1;
            if (n == 11 + L) abort = 1'b0;
        end
        // Abort and trigger edge in the same IDLE cycle: abort wins.
        trig = 1'b1;
        if (L == 0) abort = 1'b1;
        for (int n = 1; n <= 4 + L; n++) begin
            step();
            vectors += 2;
            if (rf !== 1'b0)   begin miscompares++; $display("FAIL abort_idle_rf n=%0d got %b want 0", n, rf); end
            if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle_busy n=%0d got %b want 0", n, busy); end
            $display("abort_idle n=%0d rf=%b busy=%b", n, rf, busy);
            if (n == L && L > 0) abort = 1'b1;
            if (n == L + 1) begin abort = 1'b0; trig = 1'b0; end
        end
        repeat (3) step();
    endtask

    // Zero lengths clamp to 1; edge on DONE is a miss; edge on first IDLE cycle is accepted.
    task automatic test_zero_b2b();
        logic e_rf, e_busy, e_done, e_tm;
        half_pi_len = '0; tau_len = '0; n_pi = '0;
        trig = 1'b1;
        for (int n = 1; n <= 5 + L; n++) begin
            int c;
            step();
            c = n - L;
            e_rf   = (c == 1) || (c == 3);
            e_busy = (c >= 1 && c <= 3);
            e_done = (c == 4);
            e_tm   = (c >= 5);
            vectors += 4;
            if (rf !== e_rf)          begin miscompares++; $display("FAIL zero_rf c=%0d got %b want %b", c, rf, e_rf); end
            if (busy !== e_busy)      begin miscompares++; $display("FAIL zero_busy c=%0d got %b want %b", c, busy, e_busy); end
            if (done !== e_done)      begin miscompares++; $display("FAIL zero_done c=%0d got %b want %b", c, done, e_done); end
            if (trig_missed !== e_tm) begin miscompares++; $display("FAIL zero_trig_missed c=%0d got %b want %b", c, trig_missed, e_tm); end
            $display("zero c=%0d rf=%b busy=%b done=%b tm=%b", c, rf, busy, done, trig_missed);
            if (n == 1) trig = 1'b0;
            if (n == 4) trig = 1'b1;
            if (n == 5) trig = 1'b0;
        end
        repeat (4) step();
        trig = 1'b1;
        for (int n = 1; n <= 11 + L; n++) begin
            int c;
            step();
            c = n - L;
            e_rf   = (c == 1) || (c == 3) || (c == 6) || (c == 8);
            e_busy = (c >= 1 && c <= 3) || (c >= 6 && c <= 8);
            e_done = (c == 4) || (c == 9);
            vectors += 3;
            if (rf !== e_rf)     begin miscompares++; $display("FAIL b2b_rf c=%0d got %b want %b", c, rf, e_rf); end
            if (busy !== e_busy) begin miscompares++; $display("FAIL b2b_busy c=%0d got %b want %b", c, busy, e_busy); end
            if (done !== e_done) begin miscompares++; $display("FAIL b2b_done c=%0d got %b want %b", c, done, e_done); end
            if (c >= 1) begin
                vectors++;
                if (trig_missed !== 1'b0) begin miscompares++; $display("FAIL b2b_trig_missed c=%0d got %b want 0", c, trig_missed); end
            end
            $display("b2b c=%0d rf=%b busy=%b done=%b tm=%b", c, rf, busy, done, trig_missed);
            if (n == 1) trig = 1'b0;
            if (n == 5) trig = 1'b1;
            if (n == 6) trig = 1'b0;
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        logic e_on;
        half_pi_len = 16'd3; tau_len = 16'd5; n_pi = 8'd1;
        trig = 1'b1;
        for (int n = 1; n <= 5 + L; n++) begin
            int c;
            step();
            c = n - L;
            e_on = (c >= 1 && c <= 2);
            vectors += 4;
            if (rf !== e_on)          begin miscompares++; $display("FAIL rstmid_rf c=%0d got %b want %b", c, rf, e_on); end
            if (busy !== e_on)        begin miscompares++; $display("FAIL rstmid_busy c=%0d got %b want %b", c, busy, e_on); end
            if (done !== 1'b0)        begin miscompares++; $display("FAIL rstmid_done c=%0d got %b want 0", c, done); end
            if (trig_missed !== 1'b0) begin miscompares++; $display("FAIL rstmid_trig_missed c=%0d got %b want 0", c, trig_missed); end
            $display("rstmid c=%0d rf=%b busy=%b done=%b tm=%b", c, rf, busy, done, trig_missed);
            if (n == 1) trig = 1'b0;
            if (n == 2 + L) rst = 1'b1;
            if (n == 3 + L) rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_ramsey_retrig();
        test_hahn();
        test_cpmg();
        test_abort();
        test_zero_b2b();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
